// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline, long-unit, register-file, scoreboard and trace
// signals around the writeback port arbiter.
interface wb_port_arbiter_if;
  // Pipeline writeback request
  logic        pipe_valid;
  logic        pipe_ready;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic [31:0] pipe_pc;
  // Long-unit issue notification and result
  logic        lu_issue;
  logic [4:0]  lu_issue_dest;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_dest;
  logic [31:0] lu_wdata;
  logic [31:0] lu_pc;
  // Register-file write port
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  // Pending-destination scoreboard
  logic [31:0] pend_mask;
  // Retire trace
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  modport master (
    output pipe_valid, pipe_we, pipe_waddr, pipe_wdata, pipe_pc,
    output lu_issue, lu_issue_dest, lu_valid, lu_dest, lu_wdata, lu_pc,
    input  pipe_ready, lu_ready, rf_we, rf_waddr, rf_wdata, pend_mask,
    input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  pipe_valid, pipe_we, pipe_waddr, pipe_wdata, pipe_pc,
    input  lu_issue, lu_issue_dest, lu_valid, lu_dest, lu_wdata, lu_pc,
    output pipe_ready, lu_ready, rf_we, rf_waddr, rf_wdata, pend_mask,
    output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order WB stream and
// buffered long-unit results; pipeline has priority, the FIFO head is forced
// through after STARVE_LIMIT lost arbitrations. Tracks in-flight long-op
// destinations for ID hazard stalls and drives the retire trace.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_INC = SW'(1);
  localparam logic [AW:0]   PTR_INC    = (AW + 1)'(1);

  logic [4:0]    fifo_dest  [FIFO_DEPTH];
  logic [31:0]   fifo_wdata [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_d;
  logic [31:0]   pend_q;
  logic [31:0]   pend_d;

  logic          fifo_nonempty;
  logic          fifo_full;
  logic          push;
  logic          force_fifo;
  logic          grant_pipe;
  logic          grant_fifo;
  logic [4:0]    head_dest;
  logic [31:0]   head_wdata;
  logic [31:0]   head_pc;

  logic          rf_we_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;
  logic [31:0]   wb_pc_q;

  // FIFO status, arbitration and handshake decisions for this cycle
  always_comb begin
    fifo_nonempty = (wr_ptr != rd_ptr);
    fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    head_dest     = fifo_dest[rd_ptr[AW-1:0]];
    head_wdata    = fifo_wdata[rd_ptr[AW-1:0]];
    head_pc       = fifo_pc[rd_ptr[AW-1:0]];
    force_fifo    = fifo_nonempty && (starve_cnt == STARVE_MAX);
    push          = bus.lu_valid && !fifo_full;
    grant_pipe    = bus.pipe_valid && !force_fifo;
    grant_fifo    = fifo_nonempty && (force_fifo || !bus.pipe_valid);
  end

  // Next starvation count and next pending-destination mask
  always_comb begin
    starve_d = starve_cnt;
    if (!fifo_nonempty || grant_fifo) begin
      starve_d = '0;
    end else if (grant_pipe && (starve_cnt != STARVE_MAX)) begin
      starve_d = starve_cnt + STARVE_INC;
    end
    pend_d = pend_q;
    if (grant_fifo) begin
      pend_d[head_dest] = 1'b0;
    end
    // Applied after the clear so a same-cycle reissue keeps the bit set
    if (bus.lu_issue && (bus.lu_issue_dest != 5'd0)) begin
      pend_d[bus.lu_issue_dest] = 1'b1;
    end
  end

  // FIFO pointers, starvation counter and scoreboard state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      pend_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_INC;
      end
      if (grant_fifo) begin
        rd_ptr <= rd_ptr + PTR_INC;
      end
      starve_cnt <= starve_d;
      pend_q     <= pend_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_ptr[AW-1:0]]  <= bus.lu_dest;
      fifo_wdata[wr_ptr[AW-1:0]] <= bus.lu_wdata;
      fifo_pc[wr_ptr[AW-1:0]]    <= bus.lu_pc;
    end
  end

  // Write-port register: loads from the winner, r0 writes suppressed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_pc_q    <= '0;
    end else if (grant_pipe) begin
      rf_we_q    <= bus.pipe_we && (bus.pipe_waddr != 5'd0);
      rf_waddr_q <= bus.pipe_waddr;
      rf_wdata_q <= bus.pipe_wdata;
      wb_pc_q    <= bus.pipe_pc;
    end else if (grant_fifo) begin
      rf_we_q    <= (head_dest != 5'd0);
      rf_waddr_q <= head_dest;
      rf_wdata_q <= head_wdata;
      wb_pc_q    <= head_pc;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  assign bus.pipe_ready        = !force_fifo;
  assign bus.lu_ready          = !fifo_full;
  assign bus.rf_we             = rf_we_q;
  assign bus.rf_waddr          = rf_waddr_q;
  assign bus.rf_wdata          = rf_wdata_q;
  assign bus.pend_mask         = pend_q;
  assign bus.debug_wb_pc       = wb_pc_q;
  assign bus.debug_wb_rf_we    = {4{rf_we_q}};
  assign bus.debug_wb_rf_wnum  = rf_waddr_q;
  assign bus.debug_wb_rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scenario bench for wb_port_arbiter: expected register-file writes are
// queued with their due cycle as stimulus is driven and matched by a monitor.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus data generators
  function automatic logic [4:0] pa(input int i);
    return 5'((i % 31) + 1);
  endfunction
  function automatic logic [31:0] pd(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction
  function automatic logic [31:0] ppc(input int i);
    return 32'h1c00_1000 + 32'(i * 4);
  endfunction
  function automatic logic [4:0] la(input int j);
    return 5'(20 + j);
  endfunction
  function automatic logic [31:0] ld(input int j);
    return 32'hB000_0000 + 32'(j);
  endfunction
  function automatic logic [31:0] lpc(input int j);
    return 32'h1c00_2000 + 32'(j * 4);
  endfunction

  // Scoreboard monitor: every rf write must match the queue head on its due cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (bus.rf_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got waddr %0d wdata %h at cycle %0d, required no write",
                   bus.rf_waddr, bus.rf_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rf_waddr, bus.rf_wdata, bus.debug_wb_pc, bus.debug_wb_rf_wnum,
               bus.debug_wb_rf_wdata, bus.debug_wb_rf_we} !==
              {e.waddr, e.wdata, e.pc, e.waddr, e.wdata, 4'hf} || cyc != e.cyc) begin
            errors++;
            $display("FAIL rf_write: got addr %0d data %h pc %h wnum %0d twdata %h twe %h cyc %0d, required addr %0d data %h pc %h we f cyc %0d",
                     bus.rf_waddr, bus.rf_wdata, bus.debug_wb_pc, bus.debug_wb_rf_wnum,
                     bus.debug_wb_rf_wdata, bus.debug_wb_rf_we, cyc,
                     e.waddr, e.wdata, e.pc, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missing_write: got rf_we 0 at cycle %0d, required write addr %0d data %h at cycle %0d",
                 cyc, e.waddr, e.wdata, e.cyc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.pipe_valid    = 1'b0;
    bus.pipe_we       = 1'b0;
    bus.pipe_waddr    = '0;
    bus.pipe_wdata    = '0;
    bus.pipe_pc       = '0;
    bus.lu_issue      = 1'b0;
    bus.lu_issue_dest = '0;
    bus.lu_valid      = 1'b0;
    bus.lu_dest       = '0;
    bus.lu_wdata      = '0;
    bus.lu_pc         = '0;
  endtask

  task automatic drive_pipe(input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic [31:0] pc);
    bus.pipe_valid = 1'b1;
    bus.pipe_we    = we;
    bus.pipe_waddr = a;
    bus.pipe_wdata = d;
    bus.pipe_pc    = pc;
  endtask

  task automatic drive_lu(input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] pc);
    bus.lu_valid = 1'b1;
    bus.lu_dest  = a;
    bus.lu_wdata = d;
    bus.lu_pc    = pc;
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] pc, input int unsigned at);
    exp_t e;
    e.waddr = a;
    e.wdata = d;
    e.pc    = pc;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== 38'd0) begin
      errors++;
      $display("FAIL reset_rf: got we %b addr %0d data %h, required 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    checks++;
    if ({bus.debug_wb_pc, bus.debug_wb_rf_we, bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata} !== 73'd0) begin
      errors++;
      $display("FAIL reset_debug: got pc %h we %h, required 0", bus.debug_wb_pc, bus.debug_wb_rf_we);
    end
    checks++;
    if (bus.pend_mask !== 32'd0) begin
      errors++;
      $display("FAIL reset_pend: got %h, required 0", bus.pend_mask);
    end
    checks++;
    if ({bus.pipe_ready, bus.lu_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got %b%b, required 11", bus.pipe_ready, bus.lu_ready);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.pipe_ready, bus.lu_ready, bus.rf_we} !== 3'b110) begin
      errors++;
      $display("FAIL post_reset: got ready %b%b we %b, required 11 0", bus.pipe_ready, bus.lu_ready, bus.rf_we);
    end
  endtask

  task automatic test_pipeline();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_idle();
      drive_pipe(1'b1, 5'd5, 32'h1234 + 32'(i), 32'h1c00_0000 + 32'(i * 4));
      push_exp(5'd5, 32'h1234 + 32'(i), 32'h1c00_0000 + 32'(i * 4), cyc + 1);
      @(negedge clk);
      checks++;
      if (bus.pipe_ready !== 1'b1) begin
        errors++;
        $display("FAIL pipe_ready: got %b, required 1", bus.pipe_ready);
      end
    end
    next_cycle();
    set_idle();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pipeline_drain: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_r0();
    next_cycle();
    set_idle();
    drive_pipe(1'b1, 5'd0, 32'hDEAD_BEEF, 32'h1c00_0010);
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.debug_wb_rf_we, bus.debug_wb_pc} !== {1'b0, 4'h0, 32'h1c00_0010}) begin
      errors++;
      $display("FAIL r0_suppress: got we %b twe %h pc %h, required we 0 twe 0 pc 1c000010",
               bus.rf_we, bus.debug_wb_rf_we, bus.debug_wb_pc);
    end
  endtask

  task automatic test_long_idle();
    next_cycle();
    set_idle();
    bus.lu_issue      = 1'b1;
    bus.lu_issue_dest = 5'd7;
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.pend_mask[7] !== 1'b1) begin
      errors++;
      $display("FAIL pend_set: got pend_mask %h, required bit 7 set", bus.pend_mask);
    end
    next_cycle();
    drive_lu(5'd7, 32'hAA, 32'h1c00_0100);
    push_exp(5'd7, 32'hAA, 32'h1c00_0100, cyc + 2);
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.pend_mask[7] !== 1'b1) begin
      errors++;
      $display("FAIL pend_hold: got pend_mask %h, required bit 7 set", bus.pend_mask);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.pend_mask[7] !== 1'b0) begin
      errors++;
      $display("FAIL pend_clear: got pend_mask %h, required bit 7 clear", bus.pend_mask);
    end
    wait_drain();
  endtask

  task automatic test_starvation();
    logic exp_pr;
    int   idx;
    for (int t = 0; t < 6; t++) begin
      next_cycle();
      set_idle();
      exp_pr = (t != 4);
      idx    = (t <= 4) ? 10 + t : 10 + t - 1;
      drive_pipe(1'b1, pa(idx), pd(idx), ppc(idx));
      if (t == 0) drive_lu(la(5), ld(5), lpc(5));
      if (exp_pr) push_exp(pa(idx), pd(idx), ppc(idx), cyc + 1);
      else        push_exp(la(5), ld(5), lpc(5), cyc + 1);
      @(negedge clk);
      checks++;
      if (bus.pipe_ready !== exp_pr) begin
        errors++;
        $display("FAIL starve_ready_t%0d: got pipe_ready %b, required %b", t, bus.pipe_ready, exp_pr);
      end
    end
    next_cycle();
    set_idle();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL starve_drain: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] pv_v  = 8'b0011_1111;
    logic [7:0] lv_v  = 8'b0011_1111;
    logic [7:0] pr_v  = 8'b1110_1111;
    logic [7:0] lr_v  = 8'b1010_0011;
    int         pidx[8] = '{20, 21, 22, 23, 24, 24, 0, 0};
    int         lidx[8] = '{0, 1, 2, 2, 2, 2, 0, 0};
    int         wsrc[8] = '{20, 21, 22, 23, 100, 24, 101, 102};
    for (int t = 0; t < 8; t++) begin
      next_cycle();
      set_idle();
      if (pv_v[t]) drive_pipe(1'b1, pa(pidx[t]), pd(pidx[t]), ppc(pidx[t]));
      if (lv_v[t]) drive_lu(la(lidx[t]), ld(lidx[t]), lpc(lidx[t]));
      if (wsrc[t] >= 100) push_exp(la(wsrc[t] - 100), ld(wsrc[t] - 100), lpc(wsrc[t] - 100), cyc + 1);
      else                push_exp(pa(wsrc[t]), pd(wsrc[t]), ppc(wsrc[t]), cyc + 1);
      @(negedge clk);
      checks++;
      if ({bus.pipe_ready, bus.lu_ready} !== {pr_v[t], lr_v[t]}) begin
        errors++;
        $display("FAIL full_ready_t%0d: got pipe_ready %b lu_ready %b, required %b %b",
                 t, bus.pipe_ready, bus.lu_ready, pr_v[t], lr_v[t]);
      end
    end
    next_cycle();
    set_idle();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain: got %0d pending writes, required 0", exp_q.size());
    end
  endtask

  task automatic test_same_bit();
    next_cycle();
    set_idle();
    bus.lu_issue      = 1'b1;
    bus.lu_issue_dest = 5'd9;
    next_cycle();
    set_idle();
    drive_lu(5'd9, 32'h99, 32'h1c00_0900);
    push_exp(5'd9, 32'h99, 32'h1c00_0900, cyc + 2);
    next_cycle();
    set_idle();
    bus.lu_issue      = 1'b1;
    bus.lu_issue_dest = 5'd9;
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.pend_mask[9] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got pend_mask %h, required bit 9 set", bus.pend_mask);
    end
    next_cycle();
    drive_lu(5'd9, 32'h98, 32'h1c00_0904);
    push_exp(5'd9, 32'h98, 32'h1c00_0904, cyc + 2);
    next_cycle();
    set_idle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.pend_mask !== 32'd0) begin
      errors++;
      $display("FAIL same_bit_clear: got pend_mask %h, required 0", bus.pend_mask);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int wr_seen = 0;
    for (int t = 0; t < 4; t++) begin
      next_cycle();
      set_idle();
      drive_pipe(1'b1, pa(30 + t), pd(30 + t), ppc(30 + t));
      if (t < 3) push_exp(pa(30 + t), pd(30 + t), ppc(30 + t), cyc + 1);
      if (t == 0) begin bus.lu_issue = 1'b1; bus.lu_issue_dest = 5'd8; end
      if (t == 1) begin bus.lu_issue = 1'b1; bus.lu_issue_dest = 5'd9; drive_lu(5'd8, 32'h88, 32'h1c00_0800); end
      if (t == 2) drive_lu(5'd9, 32'h89, 32'h1c00_0804);
    end
    @(negedge clk);
    checks++;
    if ({bus.pend_mask, bus.lu_ready, bus.pipe_ready} !== {32'h0000_0300, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: got pend %h lu_ready %b pipe_ready %b, required 00000300 0 1",
               bus.pend_mask, bus.lu_ready, bus.pipe_ready);
    end
    #1;
    reset = 1'b1;
    set_idle();
    #1;
    checks++;
    if ({bus.pend_mask, bus.lu_ready, bus.pipe_ready, bus.rf_we} !== {32'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got pend %h lu_ready %b pipe_ready %b rf_we %b, required 0 1 1 0",
               bus.pend_mask, bus.lu_ready, bus.pipe_ready, bus.rf_we);
    end
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rf_we) wr_seen++;
    end
    checks++;
    if (wr_seen != 0 || bus.pend_mask !== 32'd0 || bus.lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got %0d writes pend %h lu_ready %b, required 0 writes pend 0 lu_ready 1",
               wr_seen, bus.pend_mask, bus.lu_ready);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    test_reset();
    test_pipeline();
    test_r0();
    test_long_idle();
    test_starvation();
    test_fifo_full();
    test_same_bit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port of the five-stage pipeline between the in-order writeback stream and a long-latency unit (divider / multi-cycle CSR ops) that completes out of pipeline order. Buffers long-unit results in a small FIFO, arbitrates the port with pipeline priority plus a starvation limit, and keeps a pending-destination scoreboard that ID uses to stall RAW hazards on in-flight long ops. Sits between the WB stage and the register file; it also drives the debug writeback trace.

## Interface
- FIFO_DEPTH, 2, long-unit result buffer entries; power of two, ≥2
- STARVE_LIMIT, 3, consecutive lost arbitrations before the FIFO head is forced through; ≥1
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pipe_valid  in  1  WB-stage instruction retiring this cycle
- pipe_ready  out  1  port accepts pipeline instruction
- pipe_we / pipe_waddr / pipe_wdata / pipe_pc  in  1/5/32/32  pipeline write request
- lu_issue  in  1  long op issued from ID this cycle
- lu_issue_dest  in  5  destination of issued long op
- lu_valid  in  1  long-unit result available
- lu_ready  out  1  FIFO can accept result
- lu_dest / lu_wdata / lu_pc  in  5/32/32  long-unit result
- rf_we / rf_waddr / rf_wdata  out  1/5/32  register-file write port
- pend_mask  out  32  bit i set: long op to ri in flight
- debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32/4/5/32  retire trace

## Operation
- FIFO push on lu_valid & lu_ready; lu_ready = !full (no same-cycle push-when-full even if popping).
- Arbitration per cycle, candidates pipeline (pipe_valid) and FIFO head (non-empty):
  - force = fifo_nonempty & (starve_cnt == STARVE_LIMIT)
  - pipe_ready = !force (independent of pipe_valid)
  - grant_pipe = pipe_valid & pipe_ready
  - grant_fifo = fifo_nonempty & (force | !pipe_valid); pops head
- starve_cnt: 0 when FIFO empty or on grant_fifo; +1 when FIFO non-empty and grant_pipe; saturates at STARVE_LIMIT.
- Port register loads on any grant: rf_waddr/rf_wdata/debug fields from winner; rf_we = winner_we & (waddr != 0), where winner_we = pipe_we for pipeline, 1 for FIFO. No grant: rf_we = 0, other fields hold.
- debug_wb_pc updates on every grant including we=0 instructions; debug_wb_rf_we = {4{rf_we}}.
- pend_mask: lu_issue sets bit lu_issue_dest (r0 never set); grant_fifo clears bit of head dest. Same bit set and cleared same cycle: set wins.
- Issue to an already-pending register is excluded by ID stalling on pend_mask; the bit simply stays set.

## Timing
- Reset (async assert): rf_we 0, rf_waddr 0, rf_wdata 0, debug outputs 0, pend_mask 0, FIFO empty, starve_cnt 0; pipe_ready 1 and lu_ready 1 during and after reset.
- Reset mid-operation discards FIFO contents and all pending bits; no write issued for them.
- Pipeline latency: accepted at cycle N -> rf_we visible N+1; back-to-back every cycle when FIFO empty.
- Long-unit latency: pushed at N -> head at N+1 -> earliest write visible N+2; pend_mask bit clears at the same edge the write appears.
- pend_mask registered: lu_issue at N -> bit visible N+1.
- Worst-case FIFO wait with pipe_valid stuck high: STARVE_LIMIT cycles, then one forced cycle with pipe_ready = 0.
- Full FIFO: lu_ready 0 until the cycle after a pop.

## Test plan
- Pipeline only: pipe_valid 3 cycles, waddr 5, wdata 0x1234/0x1235/0x1236 -> rf_we 1 on the next 3 cycles with matching data; pipe_ready constantly 1.
- r0 suppression: pipe_we 1, waddr 0, pc 0x1c000010 -> rf_we 0, debug_wb_pc 0x1c000010 next cycle.
- Idle pipeline long op: lu_issue dest 7 at N -> pend_mask[7] = 1 at N+1; lu_valid dest 7, wdata 0xAA at N+2 -> rf write r7 = 0xAA at N+4, pend_mask[7] = 0 at N+4.
- Starvation (STARVE_LIMIT 3): pipe_valid held high, one FIFO entry -> pipeline wins 3 cycles, then pipe_ready 0 for one cycle, FIFO entry written, pipe_ready returns 1.
- FIFO full: pipe_valid held high, push 2 results -> lu_ready 0; third result held stable until forced pop, then accepted; all 3 written in order.
- Edge cases: lu_issue dest 9 in same cycle FIFO head dest 9 is granted -> pend_mask[9] stays 1; reset asserted with 2 FIFO entries and pend_mask 0x0000_0300 -> no further rf_we, pend_mask 0, lu_ready 1.
